conv_mac_seq: RTL

CONV_MAC_SEQ -- requirements
Module: conv_mac_seq

---
 rtl/conv_mac_seq_if.sv | 33 +++
 rtl/conv_mac_seq.sv | 118 +++++++++++
 2 files changed

// File: rtl/conv_mac_seq_if.sv
// Handshake and weight-load bundle for conv_mac_seq.
// The widths follow the same derivation as the engine, so both must share WIDTH/F/CIN/LANES.
interface conv_mac_seq_if #(
    parameter int WIDTH = 8,
    parameter int F     = 5,
    parameter int CIN   = 3,
    parameter int LANES = 4
);
    localparam int N     = CIN * F * F;
    localparam int AW    = $clog2(N + 1);
    localparam int ACC_W = 2 * WIDTH + $clog2(N + 1);

    logic                    w_we;
    logic [AW-1:0]           w_addr;
    logic signed [WIDTH-1:0] w_data;
    logic                    in_valid;
    logic                    in_ready;
    logic [LANES*WIDTH-1:0]  in_data;
    logic                    out_valid;
    logic                    out_ready;
    logic signed [ACC_W-1:0] out_data;
    logic                    busy;

    modport master (
        output w_we, w_addr, w_data, in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, busy
    );

    modport slave (
        input  w_we, w_addr, w_data, in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, busy
    );
endinterface

// File: rtl/conv_mac_seq.sv
// Sequential convolution MAC: LANES activation/weight products per beat, registered once,
// tree-summed into a bias-preloaded accumulator; one result per frame of BEATS beats.
module conv_mac_seq #(
    parameter int WIDTH   = 8,
    parameter int F       = 5,
    parameter int CIN     = 3,
    parameter int LANES   = 4,
    parameter int RELU_EN = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    conv_mac_seq_if.slave bus
);
    localparam int N     = CIN * F * F;
    localparam int BEATS = (N + LANES - 1) / LANES;
    localparam int AW    = $clog2(N + 1);
    localparam int ACC_W = 2 * WIDTH + $clog2(N + 1);
    localparam int PW    = 2 * WIDTH;
    localparam int NP    = BEATS * LANES;
    localparam int IW    = (NP > 1) ? $clog2(NP) : 1;
    localparam int CW    = $clog2(BEATS + 1);

    typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_DRAIN, S_OUT} state_t;

    state_t                  r_state, w_next;
    logic signed [WIDTH-1:0] r_w [NP];
    logic signed [WIDTH-1:0] r_bias;
    logic [CW-1:0]           r_beat;
    logic [CW-1:0]           w_beat_cur;
    logic signed [WIDTH-1:0] w_lane_w [LANES];
    logic signed [PW-1:0]    r_prod_p0 [LANES];
    logic                    r_vld_p0;
    logic signed [ACC_W-1:0] w_sum_p0;
    logic signed [ACC_W-1:0] r_acc_p1;
    logic                    w_accept;
    logic                    w_wr_en;

    function automatic logic signed [ACC_W-1:0] tree_sum(input logic signed [PW-1:0] p [LANES]);
        logic signed [ACC_W-1:0] s;
        s = '0;
        for (int j = 0; j < LANES; j++) s = s + ACC_W'(p[j]);
        return s;
    endfunction

    function automatic logic signed [ACC_W-1:0] relu(input logic signed [ACC_W-1:0] v);
        if ((RELU_EN != 0) && v[ACC_W-1]) return '0;
        return v;
    endfunction

    assign bus.in_ready  = rst_n && ((r_state == S_IDLE) || (r_state == S_ACCUM));
    assign bus.out_valid = (r_state == S_OUT);
    assign bus.busy      = (r_state != S_IDLE);
    assign bus.out_data  = relu(r_acc_p1);

    assign w_accept   = bus.in_valid && bus.in_ready;
    assign w_wr_en    = bus.w_we && (r_state == S_IDLE);
    assign w_beat_cur = (r_state == S_IDLE) ? '0 : r_beat;
    assign w_sum_p0   = tree_sum(r_prod_p0);

    // Storage is padded to BEATS*LANES; the never-written tail stays 0 so out-of-range lanes add nothing.
    always_comb begin
        logic [IW-1:0] v_idx;
        v_idx = '0;
        for (int j = 0; j < LANES; j++) begin
            v_idx       = IW'(w_beat_cur) * IW'(LANES) + IW'(j);
            w_lane_w[j] = r_w[v_idx];
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_next = (BEATS == 1) ? S_DRAIN : S_ACCUM;
            S_ACCUM: if (w_accept && (r_beat == CW'(BEATS - 1))) w_next = S_DRAIN;
            S_DRAIN: w_next = S_OUT;
            S_OUT:   if (bus.out_ready) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NP; k++) r_w[k] <= '0;
            r_bias <= '0;
        end else if (w_wr_en) begin
            if (bus.w_addr == AW'(N)) r_bias <= bus.w_data;
            for (int k = 0; k < N; k++)
                if (bus.w_addr == AW'(k)) r_w[k] <= bus.w_data;
        end
    end

    // Stage p0: lane products of the accepted beat
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int j = 0; j < LANES; j++) r_prod_p0[j] <= '0;
            r_vld_p0 <= 1'b0;
        end else begin
            r_vld_p0 <= w_accept;
            if (w_accept)
                for (int j = 0; j < LANES; j++)
                    r_prod_p0[j] <= PW'($signed(bus.in_data[j*WIDTH +: WIDTH])) * PW'(w_lane_w[j]);
        end
    end

    // Stage p1: accumulate; first beat of a frame preloads the bias
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_beat   <= '0;
            r_acc_p1 <= '0;
        end else begin
            r_state <= w_next;
            if (w_accept) r_beat <= (r_state == S_IDLE) ? CW'(1) : r_beat + CW'(1);
            if (w_accept && (r_state == S_IDLE)) r_acc_p1 <= ACC_W'(r_bias);
            else if (r_vld_p0)                   r_acc_p1 <= r_acc_p1 + w_sum_p0;
        end
    end
endmodule
